// File: rtl/uart_pkg.sv
// Shared types and ASCII constants for the UART formatter/parser blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        NEXT
    } fmt_state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_A  = 8'h41;

endpackage

// File: rtl/uart_hex_formatter_nibble_to_ascii.sv
// Maps one 4-bit value to its uppercase ASCII hex digit.
module nibble_to_ascii
    import uart_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = CHAR_0 + {4'h0, nibble_i};
        end else begin
            ascii_o = CHAR_A + {4'h0, nibble_i} - 8'd10;
        end
    end

endmodule

// File: rtl/uart_hex_formatter.sv
// Prints one binary word as uppercase ASCII hex (MSB nibble first, optional CR LF)
// through a start/busy byte transmitter interface.
module uart_hex_formatter
    import uart_pkg::*;
#(
    parameter int unsigned NIBBLES      = 4,
    parameter int unsigned ADD_CRLF     = 1,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*NIBBLES-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   active,
    output logic                   err
);

    localparam int unsigned DW    = 4 * NIBBLES;
    localparam int unsigned NCHAR = NIBBLES + 2 * ADD_CRLF;
    localparam int unsigned IW    = $clog2(NCHAR + 1);
    localparam int unsigned TW    = $clog2(BUSY_TIMEOUT + 1);

    fmt_state_t    state_q, state_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [TW-1:0] tout_q,  tout_d;
    logic          active_q, active_d;
    logic          err_q,    err_d;

    logic [7:0]    digit_c;
    logic [7:0]    char_c;

    nibble_to_ascii u_n2a (
        .nibble_i (shift_q[DW-1 -: 4]),
        .ascii_o  (digit_c)
    );

    // The CR/LF comparisons are gated by ADD_CRLF so a truncated index
    // constant can never alias a digit position.
    always_comb begin
        char_c = digit_c;
        if (ADD_CRLF != 0) begin
            if (idx_q == IW'(NIBBLES)) begin
                char_c = CHAR_CR;
            end else if (idx_q == IW'(NIBBLES + 1)) begin
                char_c = CHAR_LF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            tout_q   <= '0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            tout_q   <= tout_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        tout_d   = tout_q;
        active_d = active_q;
        err_d    = err_q;
        tx_start = 1'b0;
        in_ready = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d  = in_data;
                    idx_d    = '0;
                    active_d = 1'b1;
                    state_d  = ISSUE;
                end
            end
            // Held here while the transmitter is busy from another source.
            ISSUE: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    tout_d   = '0;
                    state_d  = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (tout_q == TW'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = NEXT;
                end else begin
                    tout_d = tout_q + TW'(1);
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (idx_q == IW'(NCHAR - 1)) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    idx_d = idx_q + IW'(1);
                    if (idx_q < IW'(NIBBLES)) begin
                        shift_d = shift_q << 4;
                    end
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx_data = (state_q == IDLE) ? 8'h00 : char_c;
    assign active  = active_q;
    assign err     = err_q;

endmodule
